sn_acc_collect: RTL and testbench
=================================

# sn_acc_collect

Stochastic-bitstream accumulator and result collector that sits directly downstream of the stochastic-number multiplexer FSM in the MVM datapath. It consumes one SN bit per lane per cycle while the generator's "generating" flag is high. It keeps a saturating signed up/down count per lane and, when the burst ends, commits a clamped signed result plus sign and saturation flags into a single-entry output register with a valid/ready handshake. It replaces the free-running per-lane up/down counters, whose results are lost when the generate flag drops.

## Interface
- LANES, 4, number of parallel SN lanes (one per x input)
- ACC_W, 6, internal signed accumulator width per lane
- OUT_W, 4, signed width of committed result per lane (OUT_W <= ACC_W)

Reset is i_rst_udc, asynchronous, active-high; the clock is i_clk_udc.
- i_clk_udc  input  1  clock, all state on posedge
- i_rst_udc  input  1  asynchronous active-high reset
- i_gen  input  1  burst-active flag from the SN generator; bits valid when 1
- i_sn_bit  input  LANES x 1  SN bit per lane; 1 = count up, 0 = count down
- i_ready  input  1  downstream accepts held result
- o_valid  output  1  held result valid
- o_result  output  LANES x OUT_W  signed committed result per lane
- o_sign  output  LANES x 1  1 when lane result >= 0 (binary activation)
- o_sat  output  LANES x 1  1 when lane was clamped or its accumulator saturated during the burst
- o_busy  output  1  1 while in ACC state
- o_drop  output  1  one-cycle pulse when a committed burst is discarded

## Operation
- States: IDLE, ACC. Reset sends the FSM to IDLE, clears all accumulators and sticky flags, and drives every output to 0.
- IDLE, i_gen=1 sampled: move to ACC. This cycle's bits count, so each accumulator loads +1 or -1.
- ACC, i_gen=1: each lane adds +1 if its bit is 1, else -1.
  - Saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1], i.e. [-32, 31] by default.
  - Saturation sets a sticky per-lane flag.
- ACC, i_gen=0 sampled: commit, clear accumulators and sticky flags, return to IDLE. The bits sampled at this edge are ignored.
- The earliest a new burst can start is the edge after the commit edge.
- Commit per lane:
  - result = accumulator clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-8, 7].
  - sat = sticky flag OR clamp occurred.
  - sign = (result >= 0).
- Output register is single-entry:
  - Commit with o_valid=0: load, o_valid=1.
  - Commit with o_valid=1 and i_ready=1 (accept and commit at the same edge): load the new result; o_valid stays 1.
  - Commit with o_valid=1 and i_ready=0: discard the new result, keep the held result, pulse o_drop.
  - No commit, o_valid=1, i_ready=1: o_valid goes to 0. o_result, o_sign and o_sat hold their last values.
- i_sn_bit is don't-care whenever i_gen=0.
- Reset mid-burst aborts the burst. There is no commit, no o_valid, no o_drop.

## Timing
- Burst sampled at edges E0..E(N-1) with i_gen=1; i_gen=0 first sampled at edge EN.
  - o_result, o_sign, o_sat and o_valid update at EN, visible the cycle after EN.
  - Latency from the last bit to valid is 1 edge.
- o_busy is high from after E0 through EN. It is low after EN.
- o_drop is high for exactly the one cycle following EN.
- Handshake transfer happens at an edge where o_valid=1 and i_ready=1. o_valid must not depend combinationally on i_ready.
- All outputs are registered. There is no combinational input-to-output path.

## Test plan
- Reset check: assert i_rst_udc mid-cycle, then release -> every output 0, o_busy=0; the first edge with i_gen=0 leaves all outputs unchanged.
- Basic burst: i_gen=1 for 5 cycles with bits lane0 11101, lane1 00000, lane2 10101, lane3 11111, then i_gen=0 with i_ready=0 -> result.
  - o_result = {3, -5, 1, 5}, o_sign = {1,0,1,1}, o_sat = 0.
  - o_valid=1 one edge after i_gen falls; raising i_ready for one edge drops o_valid.
- Output clamp: 12-cycle burst, lane0 all 1s, lane1 all 0s, lanes 2/3 alternating starting with 1 -> result.
  - o_result = {7, -8, 0, 0}, o_sat = {1,1,0,0}, o_sign = {1,0,1,1}.
- Accumulator saturation: 40-cycle burst with lane0 all 1s, then 40 all 0s on lane1 in a second burst -> results.
  - First burst: lane0 result 7, sat 1 (internal count pinned at 31).
  - Second burst: lane1 result -8, sat 1.
  - Next burst of 3 ones -> lane0 result 3, sat 0 (sticky flag cleared).
- Backpressure: i_ready=0, burst A (+2) then burst B (-3) -> o_result stays at A values; o_drop pulses once at B's commit.
  - A burst C committing at an edge with i_ready=1 -> o_valid stays 1 and o_result becomes C.
- Reset mid-burst: assert reset at cycle 3 of a 6-cycle burst, release, then run a 2-cycle all-1 burst -> no valid from the aborted burst; next result {2,2,2,2}.

Source files
------------

// File: rtl/sn_acc_collect_if.sv
// rtl/sn_acc_collect_if.sv - handshake/bus bundle for the SN accumulator collector
//
// Purpose: groups the burst input (i_gen, i_sn_bit), the result handshake
// (o_valid, i_ready) and the result/status outputs of sn_acc_collect.
// Ports (via modports):
//   master : drives i_gen, i_sn_bit, i_ready; observes all o_* signals
//   slave  : the collector itself; consumes i_*, drives o_*
//   i_gen     1            burst-active flag, SN bits valid when 1
//   i_sn_bit  LANES        one SN bit per lane, 1 = up, 0 = down
//   i_ready   1            downstream accepts the held result
//   o_valid   1            held result valid
//   o_result  LANES*OUT_W  signed clamped result, lane 0 in the low bits
//   o_sign    LANES        lane result >= 0
//   o_sat     LANES        lane clamped or accumulator saturated
//   o_busy    1            accumulating
//   o_drop    1            one-cycle pulse when a commit is discarded
interface sn_acc_collect_if #(
  parameter int LANES = 4,
  parameter int OUT_W = 4
);
  logic                     i_gen;
  logic [LANES-1:0]         i_sn_bit;
  logic                     i_ready;
  logic                     o_valid;
  logic [LANES*OUT_W-1:0]   o_result;
  logic [LANES-1:0]         o_sign;
  logic [LANES-1:0]         o_sat;
  logic                     o_busy;
  logic                     o_drop;

  modport master (
    output i_gen, i_sn_bit, i_ready,
    input  o_valid, o_result, o_sign, o_sat, o_busy, o_drop
  );

  modport slave (
    input  i_gen, i_sn_bit, i_ready,
    output o_valid, o_result, o_sign, o_sat, o_busy, o_drop
  );
endinterface

// File: rtl/sn_acc_collect.sv
// rtl/sn_acc_collect.sv - per-lane saturating SN up/down accumulator with single-entry result register
//
// Purpose: counts one stochastic bit per lane per cycle while i_gen is high,
// and when the burst ends commits a clamped signed result plus sign and
// saturation flags into a single-entry valid/ready output register.
// Ports:
//   i_clk_udc  clock, all state on posedge
//   i_rst_udc  asynchronous active-high reset
//   bus        sn_acc_collect_if.slave (i_gen, i_sn_bit, i_ready in;
//              o_valid, o_result, o_sign, o_sat, o_busy, o_drop out)
module sn_acc_collect #(
  parameter int LANES = 4,
  parameter int ACC_W = 6,
  parameter int OUT_W = 4
) (
  input  logic               i_clk_udc,
  input  logic               i_rst_udc,
  sn_acc_collect_if.slave    bus
);

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] ACC_NEG_ONE = {ACC_W{1'b1}};
  // Output range expressed at accumulator width so the clamp is a plain signed compare.
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                  state;
  logic signed [ACC_W-1:0] acc [LANES];
  logic [LANES-1:0]        sticky;

  logic                    valid_q;
  logic [LANES*OUT_W-1:0]  result_q;
  logic [LANES-1:0]        sign_q;
  logic [LANES-1:0]        sat_q;
  logic                    busy_q;
  logic                    drop_q;

  logic [OUT_W-1:0]        res_d [LANES];
  logic [LANES-1:0]        clamp_hit;
  logic                    commit;

  // Burst ends when i_gen is seen low while accumulating; that edge's bits are ignored.
  assign commit = (state == ST_ACC) && !bus.i_gen;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      res_d[l]     = acc[l][OUT_W-1:0];
      clamp_hit[l] = 1'b0;
      if (acc[l] > OUT_MAX) begin
        res_d[l]     = OUT_MAX[OUT_W-1:0];
        clamp_hit[l] = 1'b1;
      end else if (acc[l] < OUT_MIN) begin
        res_d[l]     = OUT_MIN[OUT_W-1:0];
        clamp_hit[l] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
    if (i_rst_udc) begin
      state    <= ST_IDLE;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
      sticky   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      sign_q   <= '0;
      sat_q    <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.i_gen) begin
            // The starting edge's bits already count.
            state  <= ST_ACC;
            busy_q <= 1'b1;
            for (int l = 0; l < LANES; l++)
              acc[l] <= bus.i_sn_bit[l] ? ACC_ONE : ACC_NEG_ONE;
          end
        end
        ST_ACC: begin
          if (bus.i_gen) begin
            for (int l = 0; l < LANES; l++) begin
              if (bus.i_sn_bit[l]) begin
                if (acc[l] == ACC_MAX) sticky[l] <= 1'b1;
                else                   acc[l]    <= acc[l] + ACC_ONE;
              end else begin
                if (acc[l] == ACC_MIN) sticky[l] <= 1'b1;
                else                   acc[l]    <= acc[l] + ACC_NEG_ONE;
              end
            end
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            sticky <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A held result that is being accepted this edge frees the slot for the new commit.
      if (commit) begin
        if (!valid_q || bus.i_ready) begin
          valid_q <= 1'b1;
          for (int l = 0; l < LANES; l++) begin
            result_q[l*OUT_W +: OUT_W] <= res_d[l];
            sign_q[l]                  <= ~res_d[l][OUT_W-1];
            sat_q[l]                   <= sticky[l] | clamp_hit[l];
          end
        end else begin
          drop_q <= 1'b1;
        end
      end else if (valid_q && bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_sign   = sign_q;
  assign bus.o_sat    = sat_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_drop   = drop_q;

endmodule

// File: tb/tb_sn_acc_collect.sv
// tb/tb_sn_acc_collect.sv - scoreboard bench for sn_acc_collect
module tb_sn_acc_collect;
  localparam int LANES = 4;
  localparam int ACC_W = 6;
  localparam int OUT_W = 4;
  localparam int AMAX  = 31;
  localparam int AMIN  = -32;
  localparam int OMAX  = 7;
  localparam int OMIN  = -8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sn_acc_collect_if #(.LANES(LANES), .OUT_W(OUT_W)) bus ();

  sn_acc_collect #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .i_clk_udc (clk),
    .i_rst_udc (rst),
    .bus       (bus)
  );

  typedef struct {
    logic [LANES*OUT_W-1:0] res;
    logic [LANES-1:0]       sign;
    logic [LANES-1:0]       sat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference: running signed count per lane, pinned at the accumulator range.
  int m_cnt [LANES];
  bit m_sticky [LANES];
  bit m_busy;
  bit m_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply inputs for the next edge, advance the reference through that edge, check after it.
  task automatic step(input bit gen, input logic [LANES-1:0] bits, input bit rdy);
    bit   drop_exp;
    exp_t e;
    int   r;
    int   n;
    bus.i_gen    = gen;
    bus.i_sn_bit = bits;
    bus.i_ready  = rdy;
    @(posedge clk);
    drop_exp = 1'b0;
    if (m_busy && !gen) begin
      for (int l = 0; l < LANES; l++) begin
        r = (m_cnt[l] > OMAX) ? OMAX : ((m_cnt[l] < OMIN) ? OMIN : m_cnt[l]);
        e.res[l*OUT_W +: OUT_W] = r[OUT_W-1:0];
        e.sign[l] = (r >= 0);
        e.sat[l]  = m_sticky[l] || (r != m_cnt[l]);
      end
      if (!m_valid || rdy) begin
        sb.push_back(e);
        m_valid = 1'b1;
      end else begin
        drop_exp = 1'b1;
      end
      m_busy = 1'b0;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (gen) begin
      if (!m_busy) begin
        m_busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          m_cnt[l]    = bits[l] ? 1 : -1;
          m_sticky[l] = 1'b0;
        end
      end else begin
        for (int l = 0; l < LANES; l++) begin
          n = m_cnt[l] + (bits[l] ? 1 : -1);
          if (n > AMAX || n < AMIN) m_sticky[l] = 1'b1;
          else                      m_cnt[l]    = n;
        end
      end
    end
    #1;
    chk("valid", bus.o_valid, m_valid);
    chk("busy", bus.o_busy, m_busy);
    chk("drop", bus.o_drop, drop_exp);
  endtask

  // Bit c of lane l is p[l][n-1-c], so patterns read left to right in time.
  task automatic burst(input int n, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [63:0] p2, input logic [63:0] p3,
                       input bit rdy_during, input bit rdy_end);
    logic [63:0]      p [LANES];
    logic [LANES-1:0] b;
    p = '{p0, p1, p2, p3};
    for (int c = 0; c < n; c++) begin
      for (int l = 0; l < LANES; l++) b[l] = p[l][n-1-c];
      step(1'b1, b, rdy_during);
    end
    step(1'b0, LANES'($urandom), rdy_end);
  endtask

  task automatic rand_burst();
    int               n;
    int               mode [LANES];
    logic [LANES-1:0] b;
    n = $urandom_range(1, 45);
    for (int l = 0; l < LANES; l++) mode[l] = $urandom_range(0, 3);
    for (int c = 0; c < n; c++) begin
      for (int l = 0; l < LANES; l++) begin
        case (mode[l])
          0:       b[l] = 1'b1;
          1:       b[l] = 1'b0;
          2:       b[l] = 1'($urandom_range(0, 1));
          default: b[l] = ($urandom_range(0, 3) != 0);
        endcase
      end
      step(1'b1, b, 1'($urandom_range(0, 1)));
    end
    step(1'b0, LANES'($urandom), 1'($urandom_range(0, 1)));
    repeat ($urandom_range(0, 2)) step(1'b0, LANES'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    bus.i_gen    = 1'b0;
    bus.i_ready  = 1'b0;
    bus.i_sn_bit = '0;
    #3 rst = 1'b1;
    #1;
    m_busy  = 1'b0;
    m_valid = 1'b0;
    sb.delete();
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_drop", bus.o_drop, 0);
    chk("rst_result", bus.o_result, 0);
    chk("rst_sign", bus.o_sign, 0);
    chk("rst_sat", bus.o_sat, 0);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // Monitor: every handshake transfer must carry the oldest predicted result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer actual=%0h required=none", bus.o_result);
      end else begin
        e = sb.pop_front();
        chk("sb_result", bus.o_result, e.res);
        chk("sb_sign", bus.o_sign, e.sign);
        chk("sb_sat", bus.o_sat, e.sat);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_gen    = 1'b0;
    bus.i_sn_bit = '0;
    bus.i_ready  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    step(1'b0, '1, 1'b0);
    chk("idle_result", bus.o_result, 0);
    chk("idle_sign", bus.o_sign, 0);
    chk("idle_sat", bus.o_sat, 0);

    // Basic burst: lanes {3,-5,1,5}
    burst(5, 64'b11101, 64'b00000, 64'b10101, 64'b11111, 1'b0, 1'b0);
    chk("basic_result", bus.o_result, 16'h51B3);
    chk("basic_sign", bus.o_sign, 4'b1101);
    chk("basic_sat", bus.o_sat, 4'b0000);
    step(1'b0, '0, 1'b1);

    // Output clamp: {7,-8,0,0}
    burst(12, 64'hFFF, 64'h000, 64'hAAA, 64'hAAA, 1'b0, 1'b0);
    chk("clamp_result", bus.o_result, 16'h0087);
    chk("clamp_sign", bus.o_sign, 4'b1101);
    chk("clamp_sat", bus.o_sat, 4'b0011);
    step(1'b0, '0, 1'b1);

    // Accumulator saturation and sticky clear
    burst(40, 64'hFF_FFFF_FFFF, 64'hAA_AAAA_AAAA, 64'hAA_AAAA_AAAA, 64'hAA_AAAA_AAAA, 1'b0, 1'b0);
    chk("sat1_lane0", bus.o_result[3:0], 4'd7);
    chk("sat1_flag0", bus.o_sat[0], 1'b1);
    step(1'b0, '0, 1'b1);
    burst(40, 64'hAA_AAAA_AAAA, 64'h0, 64'hAA_AAAA_AAAA, 64'hAA_AAAA_AAAA, 1'b0, 1'b0);
    chk("sat2_lane1", bus.o_result[7:4], 4'h8);
    chk("sat2_flag1", bus.o_sat[1], 1'b1);
    step(1'b0, '0, 1'b1);
    burst(3, 64'b111, 64'b101, 64'b101, 64'b101, 1'b0, 1'b0);
    chk("sat3_lane0", bus.o_result[3:0], 4'd3);
    chk("sat3_flag0", bus.o_sat[0], 1'b0);
    step(1'b0, '0, 1'b1);

    // Backpressure: A held, B dropped, C replaces A on accept-and-commit
    burst(2, 64'b11, 64'b11, 64'b11, 64'b11, 1'b0, 1'b0);
    burst(3, 64'b0, 64'b0, 64'b0, 64'b0, 1'b0, 1'b0);
    chk("bp_hold", bus.o_result, 16'h2222);
    burst(4, 64'hF, 64'hF, 64'hF, 64'hF, 1'b0, 1'b1);
    chk("bp_replace", bus.o_result, 16'h4444);
    step(1'b0, '0, 1'b1);

    // Reset mid-burst
    repeat (3) step(1'b1, '1, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b0);
    burst(2, 64'b11, 64'b11, 64'b11, 64'b11, 1'b0, 1'b0);
    chk("post_rst_result", bus.o_result, 16'h2222);
    step(1'b0, '0, 1'b1);

    repeat (40) rand_burst();

    repeat (4) step(1'b0, '0, 1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
